// File: rtl/grf_pkg.sv
// rtl/grf_pkg.sv - shared constants for the multi-port general register file
package grf_pkg;
  localparam int    DATA_W_DEF = 32;
  localparam int    ADDR_W_DEF = 5;
  localparam int    REG_ZERO   = 0;
  localparam string TRACE_FMT  = "%d@%h: $%d <= %h";
endpackage

// File: rtl/grf_sb_cnt.sv
// rtl/grf_sb_cnt.sv - saturating in-flight write counter for one register
module grf_sb_cnt #(
  parameter int CNT_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);
  localparam int SW = (((CNT_W + 1) > DEC_W) ? (CNT_W + 1) : DEC_W) + 1;
  localparam logic [SW-1:0] MAX = SW'((1 << CNT_W) - 1);

  logic [SW-1:0]    up;
  logic [SW-1:0]    down;
  logic [SW-1:0]    diff;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Issue is added before write-backs are removed, so issue+write-back at zero nets out cleanly.
  always_comb begin
    up    = SW'(cnt_q) + SW'(inc);
    down  = SW'(dec);
    diff  = up - down;
    err   = 1'b0;
    cnt_d = cnt_q;
    if (down > up) begin
      cnt_d = '0;
      err   = 1'b1;
    end else if (diff > MAX) begin
      err   = 1'b1;
    end else begin
      cnt_d = diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/grf_mp.sv
// rtl/grf_mp.sv - multi-port register file with write-through bypass and in-flight scoreboard
module grf_mp
  import grf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int CNT_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NWR*32-1:0]     wr_pc,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic                  sb_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int DEC_W = $clog2(NWR + 1);
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0]             mem [DEPTH];
  logic [DEPTH-1:0][DEC_W-1:0]   dec;
  logic [DEPTH-1:0][CNT_W-1:0]   cnt;
  logic [DEPTH-1:0]              err_v;
  logic                          sb_err_q;

  always_comb begin
    dec = '0;
    for (int r = 1; r < DEPTH; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))
          dec[r] = dec[r] + DEC_W'(1);
      end
    end
  end

  assign cnt[0]   = '0;
  assign err_v[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_sb
    grf_sb_cnt #(.CNT_W(CNT_W), .DEC_W(DEC_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (iss_en && iss_addr == ADDR_W'(r)),
      .dec   (dec[r]),
      .cnt   (cnt[r]),
      .err   (err_v[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) sb_err_q <= 1'b0;
    else if (|err_v) sb_err_q <= 1'b1;
  end

  assign sb_err = sb_err_q;

  // Ascending port order makes the youngest write land last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] != ZERO)
          mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j])
          $display("%s", $sformatf(TRACE_FMT, $time, wr_pc[j*32 +: 32],
                   wr_addr[j*ADDR_W +: ADDR_W], wr_data[j*DATA_W +: DATA_W]));
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*ADDR_W +: ADDR_W];
      if (!reset && a != ZERO) begin
        rd_data[k*DATA_W +: DATA_W] = mem[a];
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*ADDR_W +: ADDR_W] == a)
            rd_data[k*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
        // A write-back this cycle releases the stall because the bypass already supplies the value.
        rd_busy[k] = int'(cnt[a]) > int'(dec[a]);
      end
    end
  end
endmodule

// File: doc/grf_mp.md
Name: grf_mp

Overview:
- Parametrised multi-port general register file; successor to the single-write, two-read GRF.
- Configurable data width, register count, read-port count and write-port count.
- Write-through bypass on every read port.
- Per-register in-flight write scoreboard, so the decode stage can stall on a pending producer without an external hazard unit.
- Sits in ID: reads at decode; writes from the WB stage(s).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NRD, 2, number of read ports
- NWR, 2, number of write ports; higher index = younger instruction
- CNT_W, 2, width of the per-register in-flight counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; sampled on posedge clk
- rd_addr  in  NRD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  register named by port k has a write in flight that is not being written back this cycle
- wr_en  in  NWR  write enable per port
- wr_addr  in  NWR*ADDR_W  write address per port
- wr_data  in  NWR*DATA_W  write data per port
- wr_pc  in  NWR*32  PC of the writing instruction, used for the trace line only
- iss_en  in  1  an instruction that will write iss_addr leaves decode this cycle
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- sb_err  out  1  sticky: issue at saturated count, or write-back at zero count

Behaviour:
- Storage: 2**ADDR_W x DATA_W array. Register 0 reads 0, is never written, and is never bypassed or marked busy.
- Reset:
  - On the posedge with reset=1, all registers clear to 0, all counters clear to 0, and sb_err clears to 0.
  - wr_en and iss_en are ignored in that cycle.
  - While reset=1, rd_data and rd_busy are forced to 0.
- Write:
  - On posedge with reset=0, each port j with wr_en[j] and wr_addr[j]!=0 writes wr_data[j].
  - Same address on two ports in one cycle: the highest j wins.
- Trace: for every port with wr_en=1, including address 0, emit `$display("%d@%h: $%d <= %h", $time, wr_pc[j], wr_addr[j], wr_data[j])`. Emit lines in ascending j.
- Read, zero latency:
  - rd_data[k] = wr_data of the highest j with wr_en[j] and wr_addr[j]==rd_addr[k]!=0.
  - Otherwise rd_data[k] = array[rd_addr[k]].
  - Address 0 always returns 0.
- Scoreboard, one count cnt[r] per register r!=0:
  - inc = iss_en && iss_addr==r && r!=0.
  - dec = number of ports j with wr_en[j] && wr_addr[j]==r; r=0 never decrements.
  - next = cnt + inc - dec, updated at posedge.
  - Issue and write-back to the same r in one cycle net out; issue is counted before write-back, so cnt 0 + issue + 1 write-back gives 0 with no error.
  - Saturation: if cnt==2**CNT_W-1 and the net change is positive, cnt holds and sb_err sets.
  - Underflow: if dec exceeds cnt+inc, cnt goes to 0 and sb_err sets.
  - sb_err stays set until reset.
- rd_busy[k] = (cnt[rd_addr[k]] > dec(rd_addr[k])) && rd_addr[k]!=0. This uses dec for the current cycle, so a write-back in the same cycle releases the stall via bypass.
- The scoreboard does not depend on data: write-backs with no matching issue still write the array and flag sb_err.

Decomposition:
- Shared package `grf_pkg`:
  - DATA_W/ADDR_W defaults
  - REG_ZERO constant = 0
  - trace format string constant
- Sub-module `grf_sb_cnt`: one saturating up/down counter with an error strobe, instantiated per register 1..2**ADDR_W-1.
- Array, bypass mux and trace stay in `grf_mp`.

Test Plan:
- Reset clear: write 0xDEADBEEF to $5, assert reset 1 cycle, read $5 -> 0; rd_busy=0; sb_err=0.
- Bypass priority: same cycle, wr0($3,0x11) and wr1($3,0x22), rd_addr0=3 -> rd_data0=0x22 combinationally; next cycle array $3=0x22; two trace lines, port 0 first.
- Register 0: wr0($0,0xFFFFFFFF) -> trace line printed; read $0 = 0; iss_en with addr 0 leaves rd_busy=0 and the counter untouched.
- Scoreboard stall/release:
  - iss $7 on two consecutive cycles -> cnt=2, rd_busy=1 for reads of $7.
  - Write-back $7 -> busy stays 1.
  - Second write-back in the same cycle as a read of $7 -> rd_busy=0, rd_data = bypassed value.
- Simultaneous issue + write-back on $9 at cnt=1 -> cnt stays 1, busy=1.
- Errors:
  - Issue $4 four times (CNT_W=2) -> cnt holds at 3, sb_err=1 and stays 1 through later traffic until reset.
  - Separately, write-back $6 with cnt=0 -> array written, sb_err=1.
